gate_multi_fault: RTL and testbench
===================================

# gate_multi_fault

Parametrised faulty-lamp logic gate for the Wiring netlist: N lamp inputs plus one fault-lamp trigger per gate, instead of one lamp and one fault lamp. Each fault trigger is queued. The block then draws a pseudo-random lamp index from an on-chip LFSR and emits a one-cycle output pulse if the chosen lamp is on. It sits between Lamp_* instances and Output_*/downstream gate wires, and feeds `busy` into the top-level `wiring_running` OR.

## Interface
- `LAMP_COUNT`, 4: number of plain lamps stacked on the gate; must be ≥1.
- `QUEUE_DEPTH`, 4: maximum pending fault triggers; must be ≥1.
- `LFSR_SEED`, 16'hACE1: initial LFSR value; 0 is replaced by 16'h0001.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `logic_reset` in 1: synchronous, active-high; per-step clear of queue and FSM.
- `lamp_toggle` in LAMP_COUNT: one pulse per cycle per bit; toggles that lamp.
- `fault_trigger` in 1: fault-lamp hit pulse; enqueues one evaluation.
- `out` out 1: one-cycle output pulse.
- `lamp_state` out LAMP_COUNT: current lamp register.
- `busy` out 1: high when state≠IDLE or pending≠0.
- `overflow` out 1: sticky; a trigger was dropped.

## Operation
- Lamp register `lamp_q`: `lamp_q[i]` toggles on `lamp_toggle[i]`. Cleared only by `reset`, not by `logic_reset`.
- Pending counter has width clog2(QUEUE_DEPTH+1).
  - A trigger increments it; a dequeue decrements it; simultaneous trigger and dequeue leave it unchanged.
  - A trigger while pending==QUEUE_DEPTH with no dequeue that cycle is dropped and sets `overflow`.
- LFSR: 16-bit Galois, right shift, mask 16'hB400. It advances only in SELECT cycles.
- Draw: `IDX_W = max(1, clog2(LAMP_COUNT))`; draw = `lfsr[IDX_W-1:0]`, taken before the advance.
- FSM states:
  - IDLE: if pending>0, dequeue and go to SELECT.
  - SELECT: if draw<LAMP_COUNT, latch `sel`=draw and go to EMIT. Otherwise stay in SELECT (rejection; the LFSR advances and the draw is retried).
  - EMIT: `out` = `lamp_q[sel]`, using the registered value, so toggles arriving in the same cycle are not seen. Then, if pending>0, dequeue and go to SELECT; else go to IDLE.
- `out` is high only in EMIT cycles.
- `logic_reset` effects:
  - FSM→IDLE, pending→0, `overflow`→0.
  - Has priority over a `fault_trigger` in the same cycle; that trigger is discarded.
  - Lamps and LFSR are untouched.
- `reset` asserted mid-operation clears everything immediately. No `out` pulse is produced for queued triggers.

## Timing
- Values while `reset` is asserted: `out`=0, `busy`=0, `overflow`=0, `lamp_state`=0, LFSR=seed, FSM=IDLE, pending=0.
- Lamp toggle in cycle t is visible on `lamp_state` at t+1.
- Minimum latency: `fault_trigger` in cycle t → `out` in cycle t+3. Each rejected draw adds 1 cycle.
- Throughput: one evaluation per 2 cycles (EMIT→SELECT back-to-back).
- `busy` is high from t+1 through the EMIT cycle of the last queued event.
- `overflow` rises in the cycle after the drop.

## Structure
- Shared wiring package holds:
  - the LFSR mask constant and its width;
  - the FSM state enum (IDLE/SELECT/EMIT), reused by future random-select gates.
- One sub-module: `wiring_lfsr16` (enable, seed parameter, state output). It is reusable by other fault-lamp blocks.
- Parameter legality (LAMP_COUNT≥1, QUEUE_DEPTH≥1) is checked by elaboration-time assertions.

## Test plan
- All lamps off, one trigger at t → `out` stays 0 through t+10; `busy` high at t+1..t+3, then 0.
- LAMP_COUNT=4, seed 16'hACE1, only lamp 1 toggled on → trigger at t gives `out`=1 in exactly cycle t+3 (draw=1).
- LAMP_COUNT=3, seed 16'h0003, all lamps on → first draw 3 rejected, LFSR becomes 16'hB401 (draw 1); `out` in cycle t+4.
- QUEUE_DEPTH=2, LAMP_COUNT=4, all lamps on, `fault_trigger` high at t..t+5 → exactly one drop (at t+4); `overflow` high from t+5; 5 `out` pulses total, 2 cycles apart.
- Trigger and `logic_reset` in the same cycle with 2 already pending → `out` never pulses; pending=0; `busy`=0 next cycle; lamp_state unchanged.
- `reset` low during SELECT with 3 pending → all outputs 0 immediately. After release, the first draw reproduces the seed sequence.

Source files
------------

// File: rtl/gate_multi_fault_pkg.sv
// Shared wiring definitions for random-select fault-lamp gates:
// the LFSR geometry/mask, its step function and the selection FSM states.
package gate_multi_fault_pkg;

  localparam int               LFSR_W    = 16;
  localparam logic [LFSR_W-1:0] LFSR_MASK = 16'hB400;
  localparam logic [LFSR_W-1:0] LFSR_ZERO_SUB = 16'h0001;

  // Selection FSM shared by random-select gates
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    EMIT   = 2'd2
  } rsel_state_t;

  // One Galois step, shifting right; the mask is folded in when bit 0 leaves
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
    logic [LFSR_W-1:0] nxt;
    nxt = v >> 1;
    if (v[0]) nxt = nxt ^ LFSR_MASK;
    return nxt;
  endfunction

  // An all-zero seed would lock the LFSR, so it is substituted
  function automatic logic [LFSR_W-1:0] lfsr_seed_fix(input logic [LFSR_W-1:0] s);
    return (s == '0) ? LFSR_ZERO_SUB : s;
  endfunction

endpackage

// File: rtl/gate_multi_fault_lfsr16.sv
// 16-bit Galois LFSR that steps only when enabled; reusable by any
// fault-lamp block that needs a cheap pseudo-random draw.
module wiring_lfsr16
  import gate_multi_fault_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  output logic [LFSR_W-1:0] state
);

  localparam logic [LFSR_W-1:0] SEED_EFF = lfsr_seed_fix(SEED);

  // Reload the seed on reset, otherwise advance one step per enabled cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= SEED_EFF;
    end else if (en) begin
      state <= lfsr_step(state);
    end
  end

endmodule

// File: rtl/gate_multi_fault.sv
// Faulty-lamp gate with several plain lamps: each fault trigger is queued,
// then a lamp is picked at random and its state is emitted as a one-cycle pulse.
module gate_multi_fault
  import gate_multi_fault_pkg::*;
#(
  parameter int          LAMP_COUNT  = 4,
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  logic_reset,
  input  logic [LAMP_COUNT-1:0] lamp_toggle,
  input  logic                  fault_trigger,
  output logic                  out,
  output logic [LAMP_COUNT-1:0] lamp_state,
  output logic                  busy,
  output logic                  overflow
);

  localparam int IDX_W  = (LAMP_COUNT > 1) ? $clog2(LAMP_COUNT) : 1;
  localparam int PEND_W = $clog2(QUEUE_DEPTH + 1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(QUEUE_DEPTH);
  localparam logic [IDX_W:0]    LAMP_LIM = (IDX_W + 1)'(LAMP_COUNT);

  if (LAMP_COUNT < 1) begin : g_chk_lamp_count
    $error("gate_multi_fault: LAMP_COUNT must be at least 1");
  end
  if (QUEUE_DEPTH < 1) begin : g_chk_queue_depth
    $error("gate_multi_fault: QUEUE_DEPTH must be at least 1");
  end

  rsel_state_t          state_q;
  rsel_state_t          state_d;
  logic [PEND_W-1:0]    pend_q;
  logic [IDX_W-1:0]     sel_q;
  logic [LAMP_COUNT-1:0] lamp_q;
  logic                 ovf_q;
  logic [LFSR_W-1:0]    lfsr_state;
  logic [IDX_W-1:0]     draw;
  logic                 draw_ok;
  logic                 deq;
  logic                 accept;
  logic                 drop;
  logic                 lfsr_unused;

  // Only the low bits feed the draw; the rest merely carry the sequence
  assign lfsr_unused = ^lfsr_state[LFSR_W-1:IDX_W];

  assign draw    = lfsr_state[IDX_W-1:0];
  assign draw_ok = ({1'b0, draw} < LAMP_LIM);

  // A full queue still takes a trigger when a slot frees in the same cycle
  assign accept = fault_trigger && !logic_reset && ((pend_q != PEND_MAX) || deq);
  assign drop   = fault_trigger && !logic_reset && (pend_q == PEND_MAX) && !deq;

  wiring_lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (state_q == SELECT),
    .state (lfsr_state)
  );

  // Lamp register: each toggle bit flips its lamp; only hard reset clears it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lamp_q <= '0;
    end else begin
      lamp_q <= lamp_q ^ lamp_toggle;
    end
  end

  // Pending-trigger count; a trigger and a dequeue together cancel out
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q <= '0;
    end else if (logic_reset) begin
      pend_q <= '0;
    end else if (accept && !deq) begin
      pend_q <= pend_q + PEND_W'(1);
    end else if (!accept && deq) begin
      pend_q <= pend_q - PEND_W'(1);
    end
  end

  // Sticky drop flag, cleared by either reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else if (logic_reset) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end
  end

  // Latch the accepted draw as the lamp to report
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_q <= '0;
    end else if ((state_q == SELECT) && draw_ok) begin
      sel_q <= draw;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else if (logic_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; also decides when a pending trigger is consumed
  always_comb begin
    state_d = state_q;
    deq     = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend_q != '0) begin
          deq     = 1'b1;
          state_d = SELECT;
        end
      end
      SELECT: begin
        // Out-of-range draws are rejected and retried on the next LFSR value
        if (draw_ok) begin
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (pend_q != '0) begin
          deq     = 1'b1;
          state_d = SELECT;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM outputs; the emitted lamp value is the registered one
  always_comb begin
    out        = (state_q == EMIT) && lamp_q[sel_q];
    busy       = (state_q != IDLE) || (pend_q != '0);
    overflow   = ovf_q;
    lamp_state = lamp_q;
  end

endmodule

// File: tb/tb_gate_multi_fault.sv
// Scoreboard bench for gate_multi_fault. The reference model treats each
// accepted trigger as a job in a single-server queue and derives its start,
// emit cycle and lamp choice from the LFSR draw sequence.
module tb_gate_multi_fault;

  localparam int          LC   = 3;
  localparam int          QD   = 2;
  localparam int          IW   = 2;
  localparam logic [15:0] SEED = 16'hACE1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          logic_reset = 1'b0;
  logic          fault_trigger = 1'b0;
  logic [LC-1:0] lamp_toggle = '0;
  logic          out;
  logic          busy;
  logic          overflow;
  logic [LC-1:0] lamp_state;

  gate_multi_fault #(
    .LAMP_COUNT  (LC),
    .QUEUE_DEPTH (QD),
    .LFSR_SEED   (SEED)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .logic_reset   (logic_reset),
    .lamp_toggle   (lamp_toggle),
    .fault_trigger (fault_trigger),
    .out           (out),
    .lamp_state    (lamp_state),
    .busy          (busy),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          out;
    logic          busy;
    logic          ovf;
    logic [LC-1:0] lamps;
  } exp_t;

  typedef struct {
    int          arr;
    int          start;
    int          emit;
    int          sel;
    logic [15:0] lfsr_start;
  } job_t;

  exp_t expq[$];
  job_t jobs[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int mcyc  = 0;

  logic [LC-1:0] m_lamps;
  logic          m_ovf;
  logic [15:0]   m_lfsr;
  int            e_last;

  // Feedback polynomial x^16+x^14+x^13+x^11+1 in Galois form
  function automatic logic [15:0] adv(input logic [15:0] v);
    logic [15:0] r;
    r = {1'b0, v[15:1]};
    if (v[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  task automatic model_reset();
    jobs.delete();
    m_lamps = '0;
    m_ovf   = 1'b0;
    m_lfsr  = SEED;
    e_last  = -100;
  endtask

  task automatic schedule(input int t);
    job_t        j;
    logic [15:0] l;
    int          k;
    j.arr        = t;
    j.start      = (t + 2 > e_last + 1) ? t + 2 : e_last + 1;
    j.lfsr_start = m_lfsr;
    l = m_lfsr;
    k = 0;
    while (int'(l[IW-1:0]) >= LC) begin
      l = adv(l);
      k++;
    end
    j.sel  = int'(l[IW-1:0]);
    l      = adv(l);
    j.emit = j.start + k + 1;
    m_lfsr = l;
    e_last = j.emit;
    jobs.push_back(j);
  endtask

  task automatic cancel_jobs(input int t);
    job_t keep[$];
    bit   found;
    found = 1'b0;
    foreach (jobs[i]) begin
      if (jobs[i].emit <= t) begin
        keep.push_back(jobs[i]);
      end else if (!found) begin
        found  = 1'b1;
        m_lfsr = jobs[i].lfsr_start;
        for (int k = jobs[i].start; k <= t; k++) m_lfsr = adv(m_lfsr);
      end
    end
    jobs   = keep;
    e_last = t;
  endtask

  // One clock cycle: predict outputs for this cycle, then drive inputs
  task automatic step(input bit trig, input bit lr, input logic [LC-1:0] tog,
                      input bit hold_reset);
    exp_t e;
    int   pend;
    bit   deq_now;
    @(posedge clk);
    #1;
    cyc++;
    reset = hold_reset ? 1'b0 : 1'b1;
    if (hold_reset) begin
      model_reset();
      trig = 1'b0;
      lr   = 1'b0;
      tog  = '0;
    end
    e.lamps = m_lamps;
    e.ovf   = m_ovf;
    e.out   = 1'b0;
    e.busy  = 1'b0;
    foreach (jobs[i]) begin
      if (jobs[i].emit == cyc && m_lamps[jobs[i].sel]) e.out = 1'b1;
      if (cyc >= jobs[i].arr + 1 && cyc <= jobs[i].emit) e.busy = 1'b1;
    end
    expq.push_back(e);
    fault_trigger = trig;
    logic_reset   = lr;
    lamp_toggle   = tog;
    while (jobs.size() > 0 && jobs[0].emit < cyc) void'(jobs.pop_front());
    m_lamps = m_lamps ^ tog;
    if (lr) begin
      cancel_jobs(cyc);
      m_ovf = 1'b0;
    end else if (trig) begin
      pend    = 0;
      deq_now = 1'b0;
      foreach (jobs[i]) begin
        if (jobs[i].start - 1 >= cyc) pend++;
        if (jobs[i].start - 1 == cyc) deq_now = 1'b1;
      end
      if (pend >= QD && !deq_now) m_ovf = 1'b1;
      else schedule(cyc);
    end
  endtask

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, mcyc, act, want);
    end
  endtask

  // Monitor: compare every cycle's outputs against the scoreboard entry
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        mcyc++;
        cmp("out",        32'(out),        32'(e.out));
        cmp("busy",       32'(busy),       32'(e.busy));
        cmp("overflow",   32'(overflow),   32'(e.ovf));
        cmp("lamp_state", 32'(lamp_state), 32'(e.lamps));
      end
    end
  end

  // Stimulus
  initial begin
    logic [LC-1:0] tog;
    model_reset();
    repeat (3) step(1'b0, 1'b0, '0, 1'b1);

    // all lamps off, single trigger
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    repeat (11) step(1'b0, 1'b0, '0, 1'b0);

    // only lamp 1 lit
    step(1'b0, 1'b0, 3'b010, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    repeat (7) step(1'b0, 1'b0, '0, 1'b0);

    // all lamps lit, burst of triggers overruns the queue
    step(1'b0, 1'b0, 3'b101, 1'b0);
    repeat (6) step(1'b1, 1'b0, '0, 1'b0);
    repeat (16) step(1'b0, 1'b0, '0, 1'b0);

    // logic_reset collides with a trigger while work is pending
    repeat (3) step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, '0, 1'b0);
    repeat (8) step(1'b0, 1'b0, '0, 1'b0);

    // hard reset in the middle of a selection, then restart from the seed
    repeat (3) step(1'b1, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    repeat (2) step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, 3'b111, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    repeat (8) step(1'b0, 1'b0, '0, 1'b0);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        repeat (2) step(1'b0, 1'b0, '0, 1'b1);
      end else begin
        for (int b = 0; b < LC; b++) tog[b] = ($urandom_range(0, 9) == 0);
        step($urandom_range(0, 99) < 45, $urandom_range(0, 99) < 3, tog, 1'b0);
      end
    end
    repeat (10) step(1'b0, 1'b0, '0, 1'b0);

    repeat (3) @(posedge clk);
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0 entries left", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
